// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: scan-out, CPU, fill control and the VRAM command port.
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              VGAmode;
  logic              vga_en;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              clr_start;
  logic [DATA_W-1:0] clr_value;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_din;
  logic [DATA_W-1:0] vram_dout;

  modport slave (
    input  VGAmode, vga_en, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           clr_start, clr_value, vram_dout,
    output vga_rdata, vga_valid, cpu_ack, cpu_rdata, clr_busy, clr_done,
           vram_addr, vram_we, vram_din
  );

  modport master (
    output VGAmode, vga_en, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           clr_start, clr_value, vram_dout,
    input  vga_rdata, vga_valid, cpu_ack, cpu_rdata, clr_busy, clr_done,
           vram_addr, vram_we, vram_din
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scan-out > screen fill engine > CPU.
// VRAM read data arrives one cycle after the grant and is forwarded
// to the requester in that cycle, then held in a register.
module vram_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 12,
  parameter int GFX_WORDS = 307200,
  parameter int TXT_WORDS = 2400
) (
  input logic         clk,
  input logic         rst,
  vram_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] GFX_LAST = ADDR_W'(GFX_WORDS - 1);
  localparam logic [ADDR_W-1:0] TXT_LAST = ADDR_W'(TXT_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_e;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic              gnt_vga, gnt_fill, gnt_cpu;

  // Fixed-priority grant and VRAM command; nothing is granted during reset.
  always_comb begin
    gnt_vga       = !rst && bus.vga_en;
    gnt_fill      = !rst && !bus.vga_en && (state_q == S_FILL);
    gnt_cpu       = !rst && !bus.vga_en && (state_q != S_FILL) &&
                    bus.cpu_req && !cpu_ack_q;
    bus.vram_addr = '0;
    bus.vram_we   = 1'b0;
    bus.vram_din  = '0;
    if (gnt_vga) begin
      bus.vram_addr = bus.vga_addr;
    end else if (gnt_fill) begin
      bus.vram_addr = cnt_q;
      bus.vram_we   = 1'b1;
      bus.vram_din  = val_q;
    end else if (gnt_cpu) begin
      bus.vram_addr = bus.cpu_addr;
      bus.vram_we   = bus.cpu_we;
      bus.vram_din  = bus.cpu_we ? bus.cpu_wdata : '0;
    end
  end

  // Read return: forward vram_dout in the cycle after a read grant, else hold.
  always_comb begin
    vga_valid_d = gnt_vga;
    cpu_ack_d   = gnt_cpu;
    cpu_rd_d    = gnt_cpu && !bus.cpu_we;
    vga_rdata_d = vga_valid_q ? bus.vram_dout : vga_rdata_q;
    cpu_rdata_d = (cpu_ack_q && cpu_rd_q) ? bus.vram_dout : cpu_rdata_q;
  end

  // Fill FSM next state: inputs are latched only on the IDLE->FILL transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_start) begin
          state_d = S_FILL;
          cnt_d   = '0;
          last_d  = bus.VGAmode ? GFX_LAST : TXT_LAST;
          val_d   = bus.clr_value;
        end
      end
      S_FILL: begin
        if (gnt_fill) begin
          if (cnt_q == last_q) state_d = S_DONE;
          else                 cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and read outputs, forced to zero for the whole reset window.
  always_comb begin
    bus.clr_busy  = !rst && (state_q == S_FILL);
    bus.clr_done  = !rst && (state_q == S_DONE);
    bus.cpu_ack   = !rst && cpu_ack_q;
    bus.vga_valid = !rst && vga_valid_q;
    bus.cpu_rdata = rst ? '0 : cpu_rdata_d;
    bus.vga_rdata = rst ? '0 : vga_rdata_d;
  end

  // State registers; reset aborts any fill and drops a pending ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      val_q       <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      vga_valid_q <= 1'b0;
      vga_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      val_q       <= val_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_valid_q <= vga_valid_d;
      vga_rdata_q <= vga_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, cycle-level reference model with a
// shadow memory, directed scenarios and a randomized traffic phase.
module tb_vram_arbiter;
  localparam int AW  = 19;
  localparam int DW  = 12;
  localparam int GFX = 3000;
  localparam int TXT = 2400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GFX_WORDS(GFX), .TXT_WORDS(TXT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // VRAM: synchronous single port, read-before-write, one cycle latency.
  logic [DW-1:0] mem [2**AW];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (bus.vram_we) begin
      mem[bus.vram_addr] <= bus.vram_din;
      wr_cnt             <= wr_cnt + 1;
    end
    bus.vram_dout <= mem[bus.vram_addr];
  end

  // Reference model state: what the arbiter owes each requester next cycle.
  logic [DW-1:0] shadow [2**AW];
  bit  m_vv, m_ack, m_rd, f_busy, f_donep;
  int  m_vdata, m_vhold, m_rdata, m_chold;
  int  f_addr, f_len, f_val;
  bit  e_we, g_cpu, g_fill, idle, last_wr;
  int  e_addr, e_din, e_vd, e_cd;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", bus.clr_busy, 0);   chk("rst_done", bus.clr_done, 0);
      chk("rst_ack", bus.cpu_ack, 0);     chk("rst_vvalid", bus.vga_valid, 0);
      chk("rst_we", bus.vram_we, 0);      chk("rst_addr", bus.vram_addr, 0);
      chk("rst_din", bus.vram_din, 0);    chk("rst_crdata", bus.cpu_rdata, 0);
      chk("rst_vrdata", bus.vga_rdata, 0);
      m_vv = 0; m_ack = 0; m_rd = 0; f_busy = 0; f_donep = 0;
      m_vhold = 0; m_chold = 0;
    end else begin
      e_vd = m_vv ? m_vdata : m_vhold;
      e_cd = (m_ack && m_rd) ? m_rdata : m_chold;
      g_cpu = 0; g_fill = 0; e_we = 0; e_addr = 0; e_din = 0;
      if (bus.vga_en) e_addr = int'(bus.vga_addr);
      else if (f_busy) begin
        g_fill = 1; e_we = 1; e_addr = f_addr; e_din = f_val;
      end else if (bus.cpu_req && !m_ack) begin
        g_cpu = 1; e_we = bus.cpu_we; e_addr = int'(bus.cpu_addr);
        e_din = int'(bus.cpu_wdata);
      end
      chk("vga_valid", bus.vga_valid, int'(m_vv));
      if (m_vv) chk("vga_rdata", int'(bus.vga_rdata), e_vd);
      chk("cpu_ack", bus.cpu_ack, int'(m_ack));
      chk("cpu_rdata", int'(bus.cpu_rdata), e_cd);
      chk("clr_busy", bus.clr_busy, int'(f_busy));
      chk("clr_done", bus.clr_done, int'(f_donep));
      chk("vram_we", bus.vram_we, int'(e_we));
      chk("vram_addr", int'(bus.vram_addr), e_addr);
      if (e_we) chk("vram_din", int'(bus.vram_din), e_din);
      // advance the model by one cycle
      idle    = !f_busy && !f_donep;
      m_vhold = e_vd;
      m_chold = e_cd;
      m_vv    = bus.vga_en;
      if (bus.vga_en) m_vdata = int'(shadow[bus.vga_addr]);
      m_ack = g_cpu;
      m_rd  = g_cpu && !bus.cpu_we;
      if (g_cpu) begin
        m_rdata = int'(shadow[bus.cpu_addr]);
        if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
      end
      last_wr = 0;
      if (g_fill) begin
        shadow[f_addr] = DW'(f_val);
        f_addr++;
        if (f_addr == f_len) begin f_busy = 0; last_wr = 1; end
      end
      f_donep = last_wr;
      if (idle && bus.clr_start) begin
        f_busy = 1; f_addr = 0; f_val = int'(bus.clr_value);
        f_len  = bus.VGAmode ? GFX : TXT;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int cyc, w0, good, old;
  logic [DW-1:0] v;

  initial begin
    bus.VGAmode = 0; bus.vga_en = 0; bus.vga_addr = '0; bus.cpu_req = 0;
    bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.clr_start = 0;
    bus.clr_value = '0;
    repeat (3) tick();
    #1;
    chk("reset_we", bus.vram_we, 0);
    chk("reset_busy", bus.clr_busy, 0);
    rst = 0;
    tick();

    // Text-mode fill with no scan-out traffic: clr_start in cycle 0.
    bus.clr_value = 12'h0F1; bus.clr_start = 1; w0 = wr_cnt;
    tick(); bus.clr_start = 0; cyc = 1; #1;
    while (!bus.clr_done && cyc < 3000) begin tick(); #1; cyc++; end
    chk("txt_done_cycle", cyc, 2401);
    chk("txt_writes", wr_cnt - w0, 2400);
    tick(); #1;
    chk("txt_busy_after", bus.clr_busy, 0);
    chk("txt_done_pulse", bus.clr_done, 0);
    good = 0;
    for (int i = 0; i < TXT; i++) if (mem[i] == 12'h0F1) good++;
    chk("txt_words", good, 2400);

    // Graphics fill with scan-out every other cycle; a second clr_start with a
    // different value and mode mid-fill must be ignored.
    bus.VGAmode = 1; bus.clr_value = 12'h5A5; bus.clr_start = 1; w0 = wr_cnt;
    tick(); bus.clr_start = 0; cyc = 1;
    while (!bus.clr_done && cyc < 8000) begin
      bus.vga_en    = cyc[0];
      bus.vga_addr  = AW'($urandom_range(0, TXT - 1));
      bus.clr_start = (cyc == 100);
      if (cyc == 100) begin bus.clr_value = 12'hABC; bus.VGAmode = 0; end
      tick(); #1; cyc++;
    end
    bus.vga_en = 0; bus.clr_start = 0;
    chk("gfx_done_seen", bus.clr_done, 1);
    chk("gfx_writes", wr_cnt - w0, GFX);
    good = 0;
    for (int i = 0; i < GFX; i++) if (mem[i] == 12'h5A5) good++;
    chk("gfx_words", good, GFX);
    tick(); tick();

    // CPU write stalled by scan-out for 5 cycles.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 19'h00100;
    bus.cpu_wdata = 12'h123; bus.vga_en = 1; bus.vga_addr = 19'd7;
    for (int k = 1; k <= 5; k++) begin
      #1; chk("stall_ack", bus.cpu_ack, 0); chk("stall_we", bus.vram_we, 0);
      tick();
      if (k == 5) bus.vga_en = 0;
    end
    #1;
    chk("c6_we", bus.vram_we, 1); chk("c6_addr", int'(bus.vram_addr), 'h100);
    chk("c6_din", int'(bus.vram_din), 'h123); chk("c6_ack", bus.cpu_ack, 0);
    tick(); #1;
    chk("c7_ack", bus.cpu_ack, 1);
    bus.cpu_req = 0;
    tick();

    // Held CPU read: grants no closer than every other cycle.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 19'h00100;
    #1; chk("rd_c0_ack", bus.cpu_ack, 0); chk("rd_c0_addr", int'(bus.vram_addr), 'h100);
    tick(); #1;
    chk("rd_c1_ack", bus.cpu_ack, 1); chk("rd_c1_data", int'(bus.cpu_rdata), 'h123);
    chk("rd_c1_idle", int'(bus.vram_addr), 0);
    tick(); #1;
    chk("rd_c2_ack", bus.cpu_ack, 0); chk("rd_c2_addr", int'(bus.vram_addr), 'h100);
    tick(); #1;
    chk("rd_c3_ack", bus.cpu_ack, 1); chk("rd_c3_data", int'(bus.cpu_rdata), 'h123);
    bus.cpu_req = 0;
    tick();

    // Randomized mixed traffic; the model checks every cycle.
    for (int n = 0; n < 6000; n++) begin
      if (!bus.cpu_req || bus.cpu_ack) begin
        bus.cpu_req   = $urandom_range(0, 1) == 1;
        bus.cpu_we    = $urandom_range(0, 1) == 1;
        bus.cpu_addr  = AW'($urandom_range(0, 63));
        bus.cpu_wdata = DW'($urandom);
      end
      bus.vga_en    = $urandom_range(0, 1) == 1;
      bus.vga_addr  = AW'($urandom_range(0, TXT - 1));
      bus.clr_start = $urandom_range(0, 399) == 0;
      bus.clr_value = DW'($urandom);
      bus.VGAmode   = $urandom_range(0, 1) == 1;
      tick();
    end
    bus.cpu_req = 0; bus.vga_en = 0; bus.clr_start = 0;
    cyc = 0; #1;
    while (bus.clr_busy && cyc < 10000) begin tick(); #1; cyc++; end
    chk("drain_idle", bus.clr_busy, 0);
    repeat (3) tick();

    // Fill interrupted by reset at address 1000; CPU write shares cycle 0
    // with clr_start and completes before the fill begins.
    old = int'(mem[1000]);
    v = mem[1000] ^ 12'hFFF;
    bus.VGAmode = 1; bus.clr_value = v; bus.clr_start = 1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 19'h10; bus.cpu_wdata = 12'h0AA;
    #1; chk("c40_cpu_addr", int'(bus.vram_addr), 'h10); chk("c40_cpu_we", bus.vram_we, 1);
    tick(); bus.clr_start = 0; bus.cpu_req = 0; #1;
    chk("c40_ack", bus.cpu_ack, 1); chk("c40_busy", bus.clr_busy, 1);
    chk("c40_fill_addr", int'(bus.vram_addr), 0);
    for (int k = 1; k <= 1000; k++) tick();
    rst = 1; #1;
    chk("rst_fill_we", bus.vram_we, 0);
    tick(); rst = 0; #1;
    chk("post_rst_busy", bus.clr_busy, 0); chk("post_rst_we", bus.vram_we, 0);
    chk("post_rst_done", bus.clr_done, 0);
    chk("mem999", int'(mem[999]), int'(v));
    chk("mem1000_kept", int'(mem[1000]), old);
    tick(); #1;
    chk("no_resume", bus.vram_we, 0);
    bus.VGAmode = 0; bus.clr_value = 12'h321; bus.clr_start = 1;
    tick(); bus.clr_start = 0; #1;
    chk("restart_addr", int'(bus.vram_addr), 0); chk("restart_we", bus.vram_we, 1);
    chk("restart_din", int'(bus.vram_din), 'h321);
    cyc = 0;
    while (!bus.clr_done && cyc < 3000) begin tick(); #1; cyc++; end
    chk("restart_done", bus.clr_done, 1);
    chk("mem1000_new", int'(mem[1000]), 'h321);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 19, VRAM word-address width.
REQ-002 Parameter: DATA_W, 12, VRAM word width (RGB 4:4:4, or {fg/bg attr, char code} in text mode).
REQ-003 Parameter: GFX_WORDS, 307200, clear length in graphics mode (640x480).
REQ-004 Parameter: TXT_WORDS, 2400, clear length in text mode (80x30).
REQ-005 Port: clk  in  1  single system clock (VGA pixel clock domain); all logic on its rising edge.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: VGAmode  in  1  1 = graphics, 0 = text; selects clear length.
REQ-008 Port: vga_en  in  1  scan-out read request this cycle.
REQ-009 Port: vga_addr  in  ADDR_W  scan-out read address.
REQ-010 Port: vga_rdata  out  DATA_W  scan-out read data.
REQ-011 Port: vga_valid  out  1  vga_rdata valid.
REQ-012 Port: cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-013 Port: cpu_we  in  1  1 = write, 0 = read.
REQ-014 Port: cpu_addr  in  ADDR_W  CPU address.
REQ-015 Port: cpu_wdata  in  DATA_W  CPU write data.
REQ-016 Port: cpu_ack  out  1  one-cycle completion pulse.
REQ-017 Port: cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 for reads; held otherwise.
REQ-018 Port: clr_start  in  1  pulse: start screen fill.
REQ-019 Port: clr_value  in  DATA_W  fill word.
REQ-020 Port: clr_busy  out  1  fill in progress.
REQ-021 Port: clr_done  out  1  one-cycle pulse after the last fill write.
REQ-022 Port: vram_addr / vram_we / vram_din  out  ADDR_W/1/DATA_W  single-port VRAM command.
REQ-023 Port: vram_dout  in  DATA_W  VRAM read data, 1-cycle synchronous latency.

Function
REQ-030 Exactly one requester SHALL own the VRAM port per cycle, fixed priority: VGA > fill engine > CPU.
REQ-031 Grant SHALL be decided combinationally each cycle; vram_we=1 only on fill or CPU-write grants; idle cycles drive vram_we=0, vram_addr=0.
REQ-032 VGA grant: vram_addr=vga_addr; vga_valid SHALL be 1 in the next cycle with vga_rdata=vram_dout.
REQ-033 CPU SHALL be granted only if cpu_req=1, clr_busy=0, vga_en=0, and cpu_ack is not asserted this cycle (max one CPU access per 2 cycles; no double service of a held request).
REQ-034 CPU grant in cycle t SHALL produce cpu_ack=1 in t+1; for reads cpu_rdata SHALL be registered from vram_dout in t+1.
REQ-035 A stalled CPU request SHALL wait indefinitely with no ack; inputs are sampled only in the grant cycle.
REQ-036 Fill FSM states: IDLE, FILL, DONE. IDLE->FILL on clr_start=1; latch clr_value and length (VGAmode ? GFX_WORDS : TXT_WORDS); address counter = 0.
REQ-037 In FILL, each cycle with vga_en=0 SHALL write the latched value at the counter address and increment; cycles with vga_en=1 SHALL not advance.
REQ-038 After writing address length-1, FILL->DONE; DONE asserts clr_done for one cycle, then returns to IDLE; clr_busy=1 in FILL only.
REQ-039 clr_start while clr_busy=1 or in DONE SHALL be ignored; VGAmode/clr_value changes mid-fill SHALL have no effect.
REQ-040 clr_start in the same cycle as a CPU grant: the CPU access completes; fill begins next cycle.
REQ-041 Counter SHALL be ADDR_W wide; no wrap past length-1.

Reset
REQ-050 While rst=1: fill FSM to IDLE; clr_busy, clr_done, cpu_ack, vga_valid, vram_we = 0; cpu_rdata, vga_rdata, vram_addr, vram_din = 0; any in-flight fill is aborted and partial writes are not resumed.
REQ-051 A CPU request granted in the cycle rst rises SHALL not be acked; the CPU re-issues after reset.

Verification
REQ-060 Text mode, clr_value=0x0F1, clr_start, vga_en=0 -> 2400 writes to addresses 0..2399, clr_done at cycle 2401, clr_busy low afterwards.
REQ-061 Graphics fill with vga_en=1 on alternate cycles -> exactly 307200 writes, no VGA read lost, vga_valid one cycle after every vga_en.
REQ-062 cpu_req write 0x123 @ 0x00100 with vga_en=1 for 5 cycles -> no ack for 5 cycles, write in cycle 6, cpu_ack in cycle 7.
REQ-063 CPU read @ 0x00100 after REQ-062 -> cpu_ack with cpu_rdata=0x123; a held req gives next grant no earlier than 2 cycles after the previous one.
REQ-064 rst at fill address 1000 -> outputs zero next cycle; fill stopped; new clr_start restarts at address 0.
REQ-065 clr_start repeated mid-fill with a different value -> ignored; all words equal the original value.
